// File: rtl/loop_controller_if.sv
// Handshake and index-counter bus between the loop controller and its
// environment (requester plus the downstream inner/outer index counters).
interface loop_controller_if;
  logic       start;
  logic       stall;
  logic [1:0] inner_val;
  logic [3:0] outer_val;
  logic       cnt_rst;
  logic       inner_en;
  logic       outer_en;
  logic       step_valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic [5:0] step_cnt;

  modport master (
    input  start, stall, inner_val, outer_val,
    output cnt_rst, inner_en, outer_en, step_valid, ready, busy, done, step_cnt
  );

  modport slave (
    output start, stall, inner_val, outer_val,
    input  cnt_rst, inner_en, outer_en, step_valid, ready, busy, done, step_cnt
  );
endinterface

// File: rtl/loop_controller.sv
// Nested-loop sequencer: clears external inner (0..3) / outer (3..15) counters,
// then steps through all 52 index pairs, honouring downstream stall.
module loop_controller (
  input logic               clk,
  input logic               rst,
  loop_controller_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [5:0] step_cnt_q;
  logic       step_go;
  logic       inner_wrap;
  logic       last_step;

  assign step_go    = (state == RUN) && !bus.stall;
  assign inner_wrap = (bus.inner_val == 2'd3);
  assign last_step  = inner_wrap && (bus.outer_val == 4'd15);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (step_go && last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // step_cnt is zeroed on entry to a run and otherwise holds, so the final
  // count stays visible in IDLE after completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      step_cnt_q <= 6'd0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        step_cnt_q <= 6'd0;
      else if (step_go)
        step_cnt_q <= step_cnt_q + 6'd1;
    end
  end

  assign bus.step_valid = step_go;
  assign bus.inner_en   = step_go;
  assign bus.outer_en   = step_go && inner_wrap && !last_step;
  assign bus.cnt_rst    = (state == CLEAR);
  assign bus.ready      = (state == IDLE);
  assign bus.busy       = (state == CLEAR) || (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_loop_controller.sv
// Directed self-checking bench for loop_controller with a behavioural model
// of the downstream inner/outer index counters.
module tb_loop_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  loop_controller_if lif();

  loop_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (lif)
  );

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  always @(posedge clk) edges <= edges + 1;

  logic [1:0] inner_m = 2'd0;
  logic [3:0] outer_m = 4'd3;
  assign lif.inner_val = inner_m;
  assign lif.outer_val = outer_m;

  always @(posedge clk) begin
    if (lif.cnt_rst) begin
      inner_m <= 2'd0;
      outer_m <= 4'd3;
    end else begin
      if (lif.inner_en) inner_m <= inner_m + 2'd1;
      if (lif.outer_en) outer_m <= outer_m + 4'd1;
    end
  end

  // Running event counters, sampled mid-cycle; tests compare deltas.
  int sv_cnt = 0, oe_cnt = 0, oe_sum = 0, oe_bad = 0, cr_cnt = 0, done_cnt = 0, viol = 0;
  always @(negedge clk) begin
    if (lif.step_valid) sv_cnt <= sv_cnt + 1;
    if (lif.outer_en) begin
      oe_cnt <= oe_cnt + 1;
      oe_sum <= oe_sum + int'(outer_m);
      if (inner_m != 2'd3 || outer_m == 4'd15) oe_bad <= oe_bad + 1;
    end
    if (lif.cnt_rst) cr_cnt <= cr_cnt + 1;
    if (lif.done) done_cnt <= done_cnt + 1;
    if (((lif.inner_en || lif.outer_en || lif.step_valid) &&
         (lif.stall || !lif.busy || lif.cnt_rst)) || (lif.step_valid != lif.inner_en))
      viol <= viol + 1;
  end

  int b_sv, b_oe, b_sum, b_bad, b_cr, b_done, b_viol;

  task automatic snap();
    b_sv = sv_cnt; b_oe = oe_cnt; b_sum = oe_sum; b_bad = oe_bad;
    b_cr = cr_cnt; b_done = done_cnt; b_viol = viol;
  endtask

  task automatic kick(output int s);
    @(posedge clk); #1;
    lif.start = 1'b1;
    @(posedge clk); #1;
    lif.start = 1'b0;
    s = edges;
  endtask

  task automatic run_wait(input int s, input bit use_stall, input bit poke, output int de);
    int rel;
    de = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      rel = edges - s;
      lif.stall = use_stall && (rel == 5 || rel == 12 || rel == 13 || rel == 30 || rel == 44);
      lif.start = poke && (rel == 7 || rel == 40 || lif.done);
      if (lif.done) begin
        de = edges;
        break;
      end
    end
    if (de < 0) begin
      failures++;
      $display("[TB] FAIL done_timeout: no done within 200 cycles");
    end
    @(posedge clk); #1;
    lif.stall = 1'b0;
    lif.start = 1'b0;
  endtask

  task automatic test_reset();
    lif.start = 1'b0;
    lif.stall = 1'b0;
    #12;
    checks++; if (lif.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", lif.ready); end
    checks++; if ({lif.busy, lif.done, lif.cnt_rst} !== 3'b000) begin failures++; $display("[TB] FAIL reset_status got=%b exp=000", {lif.busy, lif.done, lif.cnt_rst}); end
    checks++; if ({lif.inner_en, lif.outer_en, lif.step_valid} !== 3'b000) begin failures++; $display("[TB] FAIL reset_enables got=%b exp=000", {lif.inner_en, lif.outer_en, lif.step_valid}); end
    checks++; if (lif.step_cnt !== 6'd0) begin failures++; $display("[TB] FAIL reset_step_cnt got=%0d exp=0", lif.step_cnt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (lif.ready !== 1'b1) begin failures++; $display("[TB] FAIL release_ready got=%b exp=1", lif.ready); end
  endtask

  task automatic test_basic_run();
    int s, de;
    snap();
    kick(s);
    checks++; if ({lif.cnt_rst, lif.busy, lif.ready} !== 3'b110) begin failures++; $display("[TB] FAIL basic_clear got=%b exp=110", {lif.cnt_rst, lif.busy, lif.ready}); end
    run_wait(s, 1'b0, 1'b0, de);
    checks++; if (de !== s + 53) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", de - s, 53); end
    checks++; if (sv_cnt - b_sv !== 52) begin failures++; $display("[TB] FAIL basic_steps got=%0d exp=52", sv_cnt - b_sv); end
    checks++; if (cr_cnt - b_cr !== 1) begin failures++; $display("[TB] FAIL basic_cnt_rst got=%0d exp=1", cr_cnt - b_cr); end
    checks++; if (done_cnt - b_done !== 1) begin failures++; $display("[TB] FAIL basic_done got=%0d exp=1", done_cnt - b_done); end
    checks++; if (lif.step_cnt !== 6'd52) begin failures++; $display("[TB] FAIL basic_step_cnt got=%0d exp=52", lif.step_cnt); end
    checks++; if ({lif.ready, lif.busy} !== 2'b10) begin failures++; $display("[TB] FAIL basic_idle got=%b exp=10", {lif.ready, lif.busy}); end
    checks++; if (viol - b_viol !== 0) begin failures++; $display("[TB] FAIL basic_enable_rules got=%0d exp=0", viol - b_viol); end
  endtask

  task automatic test_outer_boundary();
    int s, de;
    snap();
    kick(s);
    run_wait(s, 1'b0, 1'b0, de);
    checks++; if (oe_cnt - b_oe !== 12) begin failures++; $display("[TB] FAIL outer_en_count got=%0d exp=12", oe_cnt - b_oe); end
    checks++; if (oe_sum - b_sum !== 102) begin failures++; $display("[TB] FAIL outer_en_values got=%0d exp=102", oe_sum - b_sum); end
    checks++; if (oe_bad - b_bad !== 0) begin failures++; $display("[TB] FAIL outer_en_misplaced got=%0d exp=0", oe_bad - b_bad); end
  endtask

  task automatic test_stall();
    int s, de;
    snap();
    kick(s);
    run_wait(s, 1'b1, 1'b0, de);
    checks++; if (de !== s + 58) begin failures++; $display("[TB] FAIL stall_latency got=%0d exp=58", de - s); end
    checks++; if (sv_cnt - b_sv !== 52) begin failures++; $display("[TB] FAIL stall_steps got=%0d exp=52", sv_cnt - b_sv); end
    checks++; if (lif.step_cnt !== 6'd52) begin failures++; $display("[TB] FAIL stall_step_cnt got=%0d exp=52", lif.step_cnt); end
    checks++; if (viol - b_viol !== 0) begin failures++; $display("[TB] FAIL stall_enables got=%0d exp=0", viol - b_viol); end
  endtask

  task automatic test_back_to_back();
    int n, d1, d2;
    n = 0; d1 = 0; d2 = 0;
    snap();
    @(posedge clk); #1;
    lif.start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (lif.done) begin
        n++;
        if (n == 1) d1 = edges;
        else begin
          d2 = edges;
          lif.start = 1'b0;
          break;
        end
      end
    end
    lif.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (n !== 2) begin failures++; $display("[TB] FAIL b2b_done_seen got=%0d exp=2", n); end
    checks++; if (d2 - d1 !== 55) begin failures++; $display("[TB] FAIL b2b_period got=%0d exp=55", d2 - d1); end
    checks++; if (done_cnt - b_done !== 2) begin failures++; $display("[TB] FAIL b2b_done_pulses got=%0d exp=2", done_cnt - b_done); end
    checks++; if (cr_cnt - b_cr !== 2) begin failures++; $display("[TB] FAIL b2b_clears got=%0d exp=2", cr_cnt - b_cr); end
    checks++; if (sv_cnt - b_sv !== 104) begin failures++; $display("[TB] FAIL b2b_steps got=%0d exp=104", sv_cnt - b_sv); end
    checks++; if ({lif.ready, lif.busy} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_idle got=%b exp=10", {lif.ready, lif.busy}); end
  endtask

  task automatic test_reset_abort();
    int s, de;
    snap();
    kick(s);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sv_cnt - b_sv >= 20) break;
    end
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if ({lif.ready, lif.busy, lif.done, lif.cnt_rst} !== 4'b1000) begin failures++; $display("[TB] FAIL abort_status got=%b exp=1000", {lif.ready, lif.busy, lif.done, lif.cnt_rst}); end
    checks++; if ({lif.inner_en, lif.outer_en, lif.step_valid} !== 3'b000) begin failures++; $display("[TB] FAIL abort_enables got=%b exp=000", {lif.inner_en, lif.outer_en, lif.step_valid}); end
    checks++; if (lif.step_cnt !== 6'd0) begin failures++; $display("[TB] FAIL abort_step_cnt got=%0d exp=0", lif.step_cnt); end
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (done_cnt - b_done !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_cnt - b_done); end
    snap();
    kick(s);
    run_wait(s, 1'b0, 1'b0, de);
    checks++; if (de !== s + 53) begin failures++; $display("[TB] FAIL abort_rerun_latency got=%0d exp=53", de - s); end
    checks++; if (sv_cnt - b_sv !== 52) begin failures++; $display("[TB] FAIL abort_rerun_steps got=%0d exp=52", sv_cnt - b_sv); end
    checks++; if (lif.step_cnt !== 6'd52) begin failures++; $display("[TB] FAIL abort_rerun_step_cnt got=%0d exp=52", lif.step_cnt); end
  endtask

  task automatic test_start_ignored();
    int s, de;
    snap();
    kick(s);
    run_wait(s, 1'b0, 1'b1, de);
    @(posedge clk); #1;
    checks++; if (de !== s + 53) begin failures++; $display("[TB] FAIL ignore_latency got=%0d exp=53", de - s); end
    checks++; if (sv_cnt - b_sv !== 52) begin failures++; $display("[TB] FAIL ignore_steps got=%0d exp=52", sv_cnt - b_sv); end
    checks++; if (cr_cnt - b_cr !== 1) begin failures++; $display("[TB] FAIL ignore_clears got=%0d exp=1", cr_cnt - b_cr); end
    checks++; if (done_cnt - b_done !== 1) begin failures++; $display("[TB] FAIL ignore_done got=%0d exp=1", done_cnt - b_done); end
    checks++; if ({lif.ready, lif.busy} !== 2'b10) begin failures++; $display("[TB] FAIL ignore_idle got=%b exp=10", {lif.ready, lif.busy}); end
    checks++; if (lif.step_cnt !== 6'd52) begin failures++; $display("[TB] FAIL ignore_step_cnt got=%0d exp=52", lif.step_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_outer_boundary();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loop_controller.md
LOOP_CONTROLLER -- requirements
Module: loop_controller

Interface
REQ-001 loop_controller SHALL have no parameters; loop bounds are fixed: inner index 0..3, outer index 3..15, 52 steps per run.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (rst=0 resets immediately, independent of clk).
REQ-004 start  input  1  request a run; sampled only in IDLE.
REQ-005 stall  input  1  downstream not ready; when 1 in RUN, no step occurs that cycle.
REQ-006 inner_val  input  2  current value of the downstream 2-bit inner index counter.
REQ-007 outer_val  input  4  current value of the downstream 4-bit outer index counter (3..15).
REQ-008 cnt_rst  output  1  synchronous active-high clear to both index counters (inner->0, outer->3).
REQ-009 inner_en  output  1  increment enable to the inner counter.
REQ-010 outer_en  output  1  increment enable to the outer counter.
REQ-011 step_valid  output  1  the current {outer_val, inner_val} is consumed this cycle.
REQ-012 ready  output  1  high in IDLE only.
REQ-013 busy  output  1  high in CLEAR and RUN.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 step_cnt  output  6  registered count of steps taken in the current or last run.

Function
REQ-016 FSM SHALL have exactly four states: IDLE, CLEAR, RUN, DONE.
REQ-017 IDLE: start=1 -> CLEAR; else stay in IDLE; step_cnt holds its value.
REQ-018 CLEAR: lasts exactly one cycle; cnt_rst=1; step_cnt loads 0; -> RUN unconditionally.
REQ-019 cnt_rst SHALL be 1 only in CLEAR.
REQ-020 RUN, stall=1: inner_en=outer_en=step_valid=0; state and step_cnt hold.
REQ-021 RUN, stall=0: step_valid=1, inner_en=1, step_cnt increments by 1 at the edge.
REQ-022 RUN, stall=0, inner_val=3, outer_val!=15: outer_en=1 in the same cycle; stay in RUN.
REQ-023 RUN, stall=0, inner_val=3, outer_val=15: outer_en=0; -> DONE (final step).
REQ-024 In all other RUN cases, outer_en SHALL be 0.
REQ-025 inner_en, outer_en and step_valid SHALL be combinational functions of state, stall, inner_val and outer_val; ready, busy, done and cnt_rst SHALL decode from the state register only.
REQ-026 DONE: done=1 for one cycle; -> IDLE unconditionally; start in DONE SHALL be ignored.
REQ-027 start SHALL be ignored in CLEAR, RUN and DONE.
REQ-028 Latency: with no stalls, done SHALL be high in the cycle following the 53rd rising edge after the edge that samples start; each stalled RUN cycle adds exactly one cycle.
REQ-029 step_cnt SHALL be 6 bits with no wrap in normal operation; it reaches 52 at DONE and holds through IDLE until the next CLEAR.
REQ-030 The controller SHALL issue no enable in IDLE, CLEAR or DONE.

Reset
REQ-031 rst=0 SHALL force state=IDLE, step_cnt=0, ready=1, busy=0, done=0, cnt_rst=0, inner_en=0, outer_en=0, step_valid=0 asynchronously.
REQ-032 rst=0 during RUN SHALL abort the run with no done pulse; after release, the next start SHALL begin a full 52-step run via CLEAR.
REQ-033 After rst returns to 1, the first state change SHALL occur no earlier than the next rising edge of clk.

Verification
REQ-034 Reset, then a start pulse with stall=0 -> one cnt_rst cycle, 52 step_valid cycles, done pulse 53 edges after the start edge, step_cnt=52, ready=1 after.
REQ-035 Run with stall=1 for 5 scattered RUN cycles -> no enables in those cycles, done delayed by exactly 5 cycles, step_cnt=52.
REQ-036 Index boundary -> outer_en=1 exactly 12 times per run, each when inner_val=3 with outer_val 3..14; never when outer_val=15.
REQ-037 start held high continuously -> runs repeat back-to-back: DONE->IDLE->CLEAR; each run yields exactly one done pulse.
REQ-038 rst=0 pulse after 20 steps -> outputs cleared immediately, no done; the next start gives a full 52-step run.
REQ-039 start pulsed during RUN and DONE -> no effect on step count, timing or state sequence.
